// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode constants, counter direction type and default sizes for pwm_multi
package pwm_pkg;
    localparam logic MODE_EDGE = 1'b0;
    localparam logic MODE_CENTER = 1'b1;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CHANNELS = 4;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one PWM channel with a double-buffered duty register, comparator and output flops
// Ports: clk, reset (async active-low), enable, tick (last cycle of period), cnt (shared counter),
//        wr_stb (accepted write for this channel), wr_duty, pending (shadow awaiting boundary),
//        pwm_out (registered compare result), pwm_out_d (pwm_out delayed one clock)
module pwm_chan import pwm_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick,
    input  logic             wr_stb,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] wr_duty,
    output logic             pending,
    output logic             pwm_out,
    output logic             pwm_out_d
);
    logic [WIDTH-1:0] shadow, active;

    // A write landing in the tick cycle is newer than any pending shadow, so it wins.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            shadow    <= '0;
            active    <= '0;
            pending   <= 1'b0;
            pwm_out   <= 1'b0;
            pwm_out_d <= 1'b0;
        end else begin
            if (tick) begin
                active  <= wr_stb ? wr_duty : (pending ? shadow : active);
                pending <= 1'b0;
            end else if (wr_stb) begin
                shadow  <= wr_duty;
                pending <= 1'b1;
            end
            pwm_out   <= enable && (cnt < active);
            pwm_out_d <= pwm_out;
        end
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with shared period counter, edge/center modes and buffered duties
// Ports: clk, reset (async active-low), enable, mode (0 edge, 1 center), period (top value P),
//        wr_valid/wr_ready/wr_chan/wr_duty (duty write port), pwm_out, pwm_out_d (one clock later),
//        period_start (pulse on the first pwm_out cycle of each period)
module pwm_multi import pwm_pkg::*; #(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                mode,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CW-1:0]       wr_chan,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] pwm_out_d,
    output logic                period_start
);
    localparam int NSEL = 1 << CW;

    logic [WIDTH-1:0]    cnt, p_act;
    logic                mode_act, tick;
    dir_t                dir;
    logic [CHANNELS-1:0] pending, wr_stb;
    logic [NSEL-1:0]     pend_ext;

    assign tick = !enable || (mode_act == MODE_EDGE ? cnt == p_act
                                                    : (dir == DIR_DOWN && cnt == WIDTH'(1)) || p_act == '0);

    // Indices past the last channel read a zero pending bit, so they are always ready and match no strobe.
    assign pend_ext = NSEL'(pending);
    assign wr_ready = !pend_ext[wr_chan] || tick;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            p_act        <= '0;
            mode_act     <= MODE_EDGE;
            period_start <= 1'b0;
        end else begin
            period_start <= enable && cnt == '0 && dir == DIR_UP;
            if (tick) begin
                cnt      <= '0;
                dir      <= DIR_UP;
                p_act    <= period;
                mode_act <= mode;
            end else if (dir == DIR_DOWN) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
                if (mode_act == MODE_CENTER && cnt + 1'b1 == p_act)
                    dir <= DIR_DOWN;
            end
        end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign wr_stb[i] = wr_valid && wr_ready && wr_chan == CW'(i);
        pwm_chan #(.WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .tick      (tick),
            .wr_stb    (wr_stb[i]),
            .cnt       (cnt),
            .wr_duty   (wr_duty),
            .pending   (pending[i]),
            .pwm_out   (pwm_out[i]),
            .pwm_out_d (pwm_out_d[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi
module tb_pwm_multi;
    typedef struct packed {
        logic [3:0] out;
        logic       ps;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, enable, mode, wr_valid, wr_ready, period_start;
    logic [7:0] period, wr_duty;
    logic [1:0] wr_chan;
    logic [3:0] pwm_out, pwm_out_d;

    logic       en6, mode6, wr_valid6, ready6, ps6;
    logic [2:0] chan6;
    logic [3:0] period6, duty6;
    logic [5:0] out6, out6_d;

    int pass_cnt = 0;
    int total_cnt = 0;
    int hi [4];

    pwm_multi #(.CHANNELS(4), .WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .period(period),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_duty(wr_duty),
        .pwm_out(pwm_out), .pwm_out_d(pwm_out_d), .period_start(period_start)
    );

    pwm_multi #(.CHANNELS(6), .WIDTH(4)) u_dut6 (
        .clk(clk), .reset(reset), .enable(en6), .mode(mode6), .period(period6),
        .wr_valid(wr_valid6), .wr_ready(ready6), .wr_chan(chan6), .wr_duty(duty6),
        .pwm_out(out6), .pwm_out_d(out6_d), .period_start(ps6)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic measure(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!period_start && n < 64);
    endtask

    task automatic run_count(input int n);
        for (int c = 0; c < 4; c++) hi[c] = 0;
        repeat (n) begin
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
            step();
        end
    endtask

    initial begin
        vec_t       edge_tab [10];
        vec_t       ctr_tab [16];
        int         dlist [4];
        logic [3:0] prev, acc;
        logic [5:0] acc6;
        int         n, h;
        edge_tab = '{{4'b1110, 1'b1}, {4'b1110, 1'b0}, {4'b1110, 1'b0}, {4'b1100, 1'b0}, {4'b1100, 1'b0},
                     {4'b1100, 1'b0}, {4'b1100, 1'b0}, {4'b1100, 1'b0}, {4'b1100, 1'b0}, {4'b1000, 1'b0}};
        ctr_tab = '{{4'b1110, 1'b1}, {4'b1110, 1'b0}, {4'b1110, 1'b0}, {4'b1100, 1'b0},
                    {4'b1100, 1'b0}, {4'b1100, 1'b0}, {4'b1100, 1'b0}, {4'b1100, 1'b0},
                    {4'b1100, 1'b0}, {4'b1100, 1'b0}, {4'b1100, 1'b0}, {4'b1100, 1'b0},
                    {4'b1100, 1'b0}, {4'b1100, 1'b0}, {4'b1110, 1'b0}, {4'b1110, 1'b0}};
        dlist = '{0, 3, 9, 10};
        reset = 1'b1; enable = 1'b0; mode = 1'b0; period = 8'd9;
        wr_valid = 1'b0; wr_chan = 2'd0; wr_duty = 8'd0;
        en6 = 1'b0; mode6 = 1'b0; period6 = 4'd5; wr_valid6 = 1'b0; chan6 = 3'd0; duty6 = 4'd0;
        #2 reset = 1'b0;
        step();
        chk("rst_out", 32'(pwm_out), 32'h0);
        chk("rst_out_d", 32'(pwm_out_d), 32'h0);
        chk("rst_ps", 32'(period_start), 32'h0);
        chk("rst_ready", 32'(wr_ready), 32'h1);
        reset = 1'b1;
        wr_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wr_chan = 2'(c);
            wr_duty = 8'(dlist[c]);
            #1 chk($sformatf("idle_ready%0d", c), 32'(wr_ready), 32'h1);
            step();
        end
        wr_valid = 1'b0;
        enable = 1'b1;
        measure(n);
        chk("first_ps", 32'(n), 32'd1);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("edge_out%0d", i), 32'(pwm_out), 32'(edge_tab[i % 10].out));
            chk($sformatf("edge_ps%0d", i), 32'(period_start), 32'(edge_tab[i % 10].ps));
            prev = pwm_out;
            step();
            chk($sformatf("edge_d%0d", i), 32'(pwm_out_d), 32'(prev));
        end
        period = 8'd4;
        measure(n);
        chk("len_old_p", 32'(n), 32'd10);
        measure(n);
        chk("len_new_p", 32'(n), 32'd5);
        mode = 1'b1;
        period = 8'd8;
        measure(n);
        chk("len_before_ctr", 32'(n), 32'd5);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("ctr_out%0d", i), 32'(pwm_out), 32'(ctr_tab[i % 16].out));
            chk($sformatf("ctr_ps%0d", i), 32'(period_start), 32'(ctr_tab[i % 16].ps));
            prev = pwm_out;
            step();
            chk($sformatf("ctr_d%0d", i), 32'(pwm_out_d), 32'(prev));
        end
        mode = 1'b0;
        period = 8'd9;
        measure(n);
        chk("len_ctr", 32'(n), 32'd16);
        repeat (2) step();
        wr_valid = 1'b1; wr_chan = 2'd1; wr_duty = 8'd5;
        #1 chk("wr1_ready", 32'(wr_ready), 32'h1);
        step();
        chk("wr2_stall", 32'(wr_ready), 32'h0);
        n = 0;
        h = 0;
        while (!wr_ready && n < 20) begin
            h += int'(pwm_out[1]);
            step();
            n++;
        end
        chk("stall_len", 32'(n), 32'd5);
        h += int'(pwm_out[1]);
        step();
        wr_valid = 1'b0;
        h += int'(pwm_out[1]);
        chk("old_duty_holds", 32'(h), 32'd0);
        step();
        chk("db_boundary_ps", 32'(period_start), 32'h1);
        run_count(10);
        chk("new_duty_hi", 32'(hi[1]), 32'd5);
        repeat (8) step();
        wr_valid = 1'b1; wr_chan = 2'd2; wr_duty = 8'd2;
        #1 chk("tick_wr_ready", 32'(wr_ready), 32'h1);
        step();
        chk("tick_wr_no_pending", 32'(wr_ready), 32'h1);
        wr_valid = 1'b0;
        step();
        chk("tick_wr_ps", 32'(period_start), 32'h1);
        run_count(10);
        chk("tick_wr_hi2", 32'(hi[2]), 32'd2);
        chk("tick_wr_hi1", 32'(hi[1]), 32'd5);
        chk("tick_wr_hi0", 32'(hi[0]), 32'd0);
        chk("tick_wr_hi3", 32'(hi[3]), 32'd10);
        repeat (3) step();
        enable = 1'b0;
        step();
        chk("dis_out", 32'(pwm_out), 32'h0);
        acc = 4'h0;
        repeat (3) begin
            step();
            acc |= pwm_out | {3'b000, period_start};
        end
        chk("dis_hold", 32'(acc), 32'h0);
        enable = 1'b1;
        measure(n);
        chk("reen_ps", 32'(n), 32'd1);
        chk("reen_out", 32'(pwm_out), 32'hE);
        repeat (2) step();
        reset = 1'b0;
        wr_valid = 1'b1; wr_chan = 2'd1;
        #1;
        chk("mid_rst_out", 32'(pwm_out), 32'h0);
        chk("mid_rst_out_d", 32'(pwm_out_d), 32'h0);
        chk("mid_rst_ps", 32'(period_start), 32'h0);
        chk("mid_rst_ready", 32'(wr_ready), 32'h1);
        repeat (2) step();
        chk("mid_rst_hold", 32'(pwm_out | pwm_out_d), 32'h0);
        wr_valid = 1'b0;
        reset = 1'b1;
        acc = 4'h0;
        repeat (12) begin
            step();
            acc |= pwm_out;
        end
        chk("duties_cleared", 32'(acc), 32'h0);
        wr_valid6 = 1'b1; chan6 = 3'd5; duty6 = 4'd2;
        #1 chk("c6_ready5", 32'(ready6), 32'h1);
        step();
        wr_valid6 = 1'b0;
        en6 = 1'b1;
        h = 0;
        repeat (6) begin
            step();
            h += int'(out6[5]);
        end
        chk("c6_hi5", 32'(h), 32'd2);
        wr_valid6 = 1'b1; chan6 = 3'd7; duty6 = 4'd5;
        #1 chk("c6_ready7", 32'(ready6), 32'h1);
        step();
        wr_valid6 = 1'b0;
        h = 0;
        acc6 = 6'h0;
        repeat (12) begin
            h += int'(out6[5]);
            acc6 |= out6 & 6'b011111;
            step();
        end
        chk("c6_oob_other", 32'(acc6), 32'h0);
        chk("c6_oob_hi5", 32'(h), 32'd4);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
